// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: FSM state encodings, response codes and the
// default protection value used by the data-side initiator.
package axil_pkg;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] RD_ADDR = 3'd1;
    localparam logic [STATE_W-1:0] RD_DATA = 3'd2;
    localparam logic [STATE_W-1:0] WR_REQ  = 3'd3;
    localparam logic [STATE_W-1:0] WR_RESP = 3'd4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/lsu_axil_master.sv
// AXI4-Lite initiator for the CPU data-memory port.
// Converts one CPU load/store (valid/ready) into one AXI4-Lite read (AR/R) or
// write (AW/W/B) transaction, one outstanding at a time, and returns a
// one-cycle response pulse with load data and error status.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req_*                      CPU request (valid/ready, wen, addr, wdata, wmask)
//   resp_valid/rdata/err       completion pulse, load data (held), xRESP[1]
//   m_ar*/m_r*                 AXI4-Lite read address / read data channels
//   m_aw*/m_w*/m_b*            AXI4-Lite write address / data / response channels
module lsu_axil_master
    import axil_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wen,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wmask,

    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,

    output logic                m_arvalid,
    input  logic                m_arready,
    output logic [ADDR_W-1:0]   m_araddr,
    output logic [2:0]          m_arprot,

    input  logic                m_rvalid,
    output logic                m_rready,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,

    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic [2:0]          m_awprot,

    output logic                m_wvalid,
    input  logic                m_wready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,

    input  logic                m_bvalid,
    output logic                m_bready,
    input  logic [1:0]          m_bresp
);

    localparam int unsigned STRB_W = DATA_W / 8;

    logic [STATE_W-1:0] state_q,      state_d;
    logic [ADDR_W-1:0]  addr_q,       addr_d;
    logic [DATA_W-1:0]  wdata_q,      wdata_d;
    logic [STRB_W-1:0]  wmask_q,      wmask_d;
    logic               aw_done_q,    aw_done_d;
    logic               w_done_q,     w_done_d;
    logic               arvalid_q,    arvalid_d;
    logic               rready_q,     rready_d;
    logic               awvalid_q,    awvalid_d;
    logic               wvalid_q,     wvalid_d;
    logic               bready_q,     bready_d;
    logic               resp_valid_q, resp_valid_d;
    logic               resp_err_q,   resp_err_d;
    logic [DATA_W-1:0]  rdata_q,      rdata_d;

    // Only xRESP[1] distinguishes error from success.
    logic unused_resp_lsb;
    assign unused_resp_lsb = m_rresp[0] ^ m_bresp[0];

    // Next-state and next-output logic; handshake valids are derived from the
    // next state so each one is a plain flop that drops the cycle after its
    // handshake.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wmask_d      = wmask_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        resp_valid_d = 1'b0;
        resp_err_d   = resp_err_q;
        rdata_d      = rdata_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    wmask_d   = req_wmask;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = req_wen ? WR_REQ : RD_ADDR;
                end
            end
            RD_ADDR: begin
                if (arvalid_q && m_arready) state_d = RD_DATA;
            end
            RD_DATA: begin
                if (m_rvalid) begin
                    rdata_d      = m_rdata;
                    resp_err_d   = m_rresp[1];
                    resp_valid_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            WR_REQ: begin
                if (awvalid_q && m_awready) aw_done_d = 1'b1;
                if (wvalid_q && m_wready)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d)  state_d   = WR_RESP;
            end
            WR_RESP: begin
                if (m_bvalid) begin
                    resp_err_d   = m_bresp[1];
                    resp_valid_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        arvalid_d = (state_d == RD_ADDR);
        rready_d  = (state_d == RD_DATA);
        awvalid_d = (state_d == WR_REQ) && !aw_done_d;
        wvalid_d  = (state_d == WR_REQ) && !w_done_d;
        bready_d  = (state_d == WR_RESP);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            wmask_q      <= '0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wmask_q      <= wmask_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            rdata_q      <= rdata_d;
        end
    end

    assign req_ready  = (state_q == IDLE);

    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = resp_err_q;

    assign m_arvalid  = arvalid_q;
    assign m_araddr   = addr_q;
    assign m_arprot   = PROT_DEFAULT;
    assign m_rready   = rready_q;

    assign m_awvalid  = awvalid_q;
    assign m_awaddr   = addr_q;
    assign m_awprot   = PROT_DEFAULT;
    assign m_wvalid   = wvalid_q;
    assign m_wdata    = wdata_q;
    assign m_wstrb    = wmask_q;
    assign m_bready   = bready_q;

endmodule

// File: tb/tb_lsu_axil_master.sv
// Directed testbench for lsu_axil_master. Inputs are driven and outputs are
// sampled on the falling clock edge; the slave side is scripted per cycle.
module tb_lsu_axil_master;

    logic        clk;
    logic        rst_n;
    logic        req_valid, req_ready, req_wen;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wmask;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        m_arvalid, m_arready;
    logic [31:0] m_araddr;
    logic [2:0]  m_arprot;
    logic        m_rvalid, m_rready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_awvalid, m_awready;
    logic [31:0] m_awaddr;
    logic [2:0]  m_awprot;
    logic        m_wvalid, m_wready;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_bvalid, m_bready;
    logic [1:0]  m_bresp;

    int errors = 0;
    int checks = 0;

    lsu_axil_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arprot(m_arprot),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awprot(m_awprot),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;
        m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = 2'b00;
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
        checks++; if ({m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready} !== 5'b0) begin errors++; $display("FAIL rst_handshakes: got %b want 00000", {m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready}); end
        checks++; if ({resp_valid, resp_err} !== 2'b00) begin errors++; $display("FAIL rst_resp: got %b want 00", {resp_valid, resp_err}); end
        checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", resp_rdata); end
        checks++; if ({m_araddr, m_wdata, m_wstrb} !== 68'h0) begin errors++; $display("FAIL rst_regs: got %h want 0", {m_araddr, m_wdata, m_wstrb}); end
        checks++; if ({m_arprot, m_awprot} !== 6'b0) begin errors++; $display("FAIL rst_prot: got %b want 000000", {m_arprot, m_awprot}); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load_zero_wait();
        // T: request presented and accepted
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0010;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL ld_req_ready_T: got %b want 1", req_ready); end
        @(negedge clk); // T+1
        req_valid = 1'b0; m_arready = 1'b1;
        checks++; if (m_arvalid !== 1'b1) begin errors++; $display("FAIL ld_arvalid_T1: got %b want 1", m_arvalid); end
        checks++; if (m_araddr !== 32'h8000_0010) begin errors++; $display("FAIL ld_araddr_T1: got %h want 80000010", m_araddr); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL ld_req_ready_T1: got %b want 0", req_ready); end
        @(negedge clk); // T+2
        m_arready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hDEAD_BEEF; m_rresp = 2'b00;
        checks++; if ({m_arvalid, m_rready} !== 2'b01) begin errors++; $display("FAIL ld_rready_T2: got arvalid,rready=%b want 01", {m_arvalid, m_rready}); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL ld_resp_early_T2: got %b want 0", resp_valid); end
        @(negedge clk); // T+3
        m_rvalid = 1'b0; m_rdata = '0;
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL ld_resp_valid_T3: got %b want 1", resp_valid); end
        checks++; if (resp_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ld_rdata: got %h want deadbeef", resp_rdata); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL ld_err: got %b want 0", resp_err); end
        checks++; if ({req_ready, m_rready} !== 2'b10) begin errors++; $display("FAIL ld_idle_T3: got req_ready,rready=%b want 10", {req_ready, m_rready}); end
        @(negedge clk); // T+4
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL ld_resp_pulse_T4: got %b want 0", resp_valid); end
        checks++; if (resp_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ld_rdata_hold: got %h want deadbeef", resp_rdata); end
    endtask

    task automatic test_store_aw_late();
        req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h8000_0004; req_wdata = 32'h1234_5678; req_wmask = 4'b0011;
        @(negedge clk); // T+1
        req_valid = 1'b0; req_wen = 1'b0; m_wready = 1'b1; m_awready = 1'b0;
        checks++; if ({m_awvalid, m_wvalid} !== 2'b11) begin errors++; $display("FAIL st_valids_T1: got aw,w=%b want 11", {m_awvalid, m_wvalid}); end
        checks++; if (m_awaddr !== 32'h8000_0004) begin errors++; $display("FAIL st_awaddr: got %h want 80000004", m_awaddr); end
        checks++; if (m_wdata !== 32'h1234_5678) begin errors++; $display("FAIL st_wdata: got %h want 12345678", m_wdata); end
        checks++; if (m_wstrb !== 4'b0011) begin errors++; $display("FAIL st_wstrb: got %b want 0011", m_wstrb); end
        @(negedge clk); // T+2
        m_wready = 1'b0;
        checks++; if ({m_awvalid, m_wvalid, m_bready} !== 3'b100) begin errors++; $display("FAIL st_T2: got aw,w,b=%b want 100", {m_awvalid, m_wvalid, m_bready}); end
        @(negedge clk); // T+3
        m_awready = 1'b1;
        checks++; if ({m_awvalid, m_wvalid, m_bready} !== 3'b100) begin errors++; $display("FAIL st_T3: got aw,w,b=%b want 100", {m_awvalid, m_wvalid, m_bready}); end
        @(negedge clk); // T+4
        m_awready = 1'b0; m_bvalid = 1'b1; m_bresp = 2'b00;
        checks++; if ({m_awvalid, m_wvalid, m_bready} !== 3'b001) begin errors++; $display("FAIL st_T4: got aw,w,b=%b want 001", {m_awvalid, m_wvalid, m_bready}); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL st_resp_early: got %b want 0", resp_valid); end
        @(negedge clk); // T+5
        m_bvalid = 1'b0;
        checks++; if ({resp_valid, resp_err} !== 2'b10) begin errors++; $display("FAIL st_resp: got valid,err=%b want 10", {resp_valid, resp_err}); end
        checks++; if (resp_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL st_rdata_unchanged: got %h want deadbeef", resp_rdata); end
        @(negedge clk);
        checks++; if ({resp_valid, m_bready} !== 2'b00) begin errors++; $display("FAIL st_after: got valid,bready=%b want 00", {resp_valid, m_bready}); end
    endtask

    task automatic test_load_delayed();
        int pulses = 0;
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0020;
        @(negedge clk);
        req_valid = 1'b0; req_addr = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            checks++; if ({m_arvalid, req_ready} !== 2'b10) begin errors++; $display("FAIL dl_ar_wait%0d: got arvalid,req_ready=%b want 10", i, {m_arvalid, req_ready}); end
            checks++; if (m_araddr !== 32'h8000_0020) begin errors++; $display("FAIL dl_araddr%0d: got %h want 80000020", i, m_araddr); end
            if (resp_valid === 1'b1) pulses++;
            if (i == 4) m_arready = 1'b1;
            @(negedge clk);
        end
        m_arready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if ({m_arvalid, m_rready, req_ready} !== 3'b010) begin errors++; $display("FAIL dl_r_wait%0d: got ar,r,req_ready=%b want 010", i, {m_arvalid, m_rready, req_ready}); end
            if (resp_valid === 1'b1) pulses++;
            @(negedge clk);
        end
        m_rvalid = 1'b1; m_rdata = 32'hCAFE_F00D;
        checks++; if (m_rready !== 1'b1) begin errors++; $display("FAIL dl_rready: got %b want 1", m_rready); end
        @(negedge clk);
        m_rvalid = 1'b0;
        if (resp_valid === 1'b1) pulses++;
        checks++; if (resp_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL dl_rdata: got %h want cafef00d", resp_rdata); end
        @(negedge clk);
        if (resp_valid === 1'b1) pulses++;
        checks++; if (pulses != 1) begin errors++; $display("FAIL dl_pulse_count: got %0d want 1", pulses); end
    endtask

    task automatic test_errors();
        // Store answered with SLVERR
        req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h0000_0100; req_wdata = 32'hA5A5_A5A5; req_wmask = 4'b0000;
        @(negedge clk);
        req_valid = 1'b0; m_awready = 1'b1; m_wready = 1'b1;
        checks++; if ({m_awvalid, m_wvalid, m_wstrb} !== 6'b110000) begin errors++; $display("FAIL er_st_zero_mask: got aw,w,strb=%b want 110000", {m_awvalid, m_wvalid, m_wstrb}); end
        @(negedge clk);
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b1; m_bresp = 2'b10;
        checks++; if (m_bready !== 1'b1) begin errors++; $display("FAIL er_st_bready: got %b want 1", m_bready); end
        @(negedge clk);
        m_bvalid = 1'b0; m_bresp = 2'b00;
        checks++; if ({resp_valid, resp_err} !== 2'b11) begin errors++; $display("FAIL er_slverr: got valid,err=%b want 11", {resp_valid, resp_err}); end
        checks++; if (resp_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL er_st_rdata: got %h want cafef00d", resp_rdata); end
        // Load answered with DECERR
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h0000_0200;
        @(negedge clk);
        req_valid = 1'b0; m_arready = 1'b1;
        @(negedge clk);
        m_arready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h0BAD_F00D; m_rresp = 2'b11;
        @(negedge clk);
        m_rvalid = 1'b0; m_rresp = 2'b00;
        checks++; if ({resp_valid, resp_err} !== 2'b11) begin errors++; $display("FAIL er_decerr: got valid,err=%b want 11", {resp_valid, resp_err}); end
        checks++; if (resp_rdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL er_ld_rdata: got %h want 0badf00d", resp_rdata); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0040; m_arready = 1'b1;
        @(negedge clk); // T+1: load in RD_ADDR; present the store already
        req_wen = 1'b1; req_addr = 32'h8000_0044; req_wdata = 32'h5555_AAAA; req_wmask = 4'b1111;
        checks++; if ({m_arvalid, m_awvalid} !== 2'b10) begin errors++; $display("FAIL bb_ignore_req: got ar,aw=%b want 10", {m_arvalid, m_awvalid}); end
        @(negedge clk); // T+2
        m_arready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h1111_2222; m_rresp = 2'b00;
        @(negedge clk); // T+3: completion, store accepted here
        m_rvalid = 1'b0;
        checks++; if ({resp_valid, req_ready} !== 2'b11) begin errors++; $display("FAIL bb_complete: got valid,req_ready=%b want 11", {resp_valid, req_ready}); end
        @(negedge clk); // T+4
        req_valid = 1'b0; req_wen = 1'b0; m_awready = 1'b1; m_wready = 1'b1;
        checks++; if ({m_awvalid, m_wvalid, req_ready} !== 3'b110) begin errors++; $display("FAIL bb_no_gap: got aw,w,req_ready=%b want 110", {m_awvalid, m_wvalid, req_ready}); end
        checks++; if (m_awaddr !== 32'h8000_0044) begin errors++; $display("FAIL bb_awaddr: got %h want 80000044", m_awaddr); end
        @(negedge clk);
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b1;
        @(negedge clk);
        m_bvalid = 1'b0;
        checks++; if ({resp_valid, resp_err} !== 2'b10) begin errors++; $display("FAIL bb_store_resp: got valid,err=%b want 10", {resp_valid, resp_err}); end
        checks++; if (resp_rdata !== 32'h1111_2222) begin errors++; $display("FAIL bb_rdata: got %h want 11112222", resp_rdata); end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0080; m_arready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk); // RD_DATA
        m_arready = 1'b0;
        checks++; if (m_rready !== 1'b1) begin errors++; $display("FAIL ar_in_rd_data: got rready=%b want 1", m_rready); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready, resp_valid} !== 6'b0) begin errors++; $display("FAIL ar_drop: got %b want 000000", {m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready, resp_valid}); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL ar_req_ready: got %b want 1", req_ready); end
        checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL ar_rdata_clear: got %h want 0", resp_rdata); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h8000_0084; m_arready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        checks++; if (m_araddr !== 32'h8000_0084) begin errors++; $display("FAIL ar_next_araddr: got %h want 80000084", m_araddr); end
        @(negedge clk);
        m_arready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h7777_8888;
        @(negedge clk);
        m_rvalid = 1'b0;
        checks++; if ({resp_valid, resp_err, resp_rdata} !== {2'b10, 32'h7777_8888}) begin errors++; $display("FAIL ar_next_load: got valid,err=%b rdata=%h want 10 77778888", {resp_valid, resp_err}, resp_rdata); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_load_zero_wait();
        test_store_aw_late();
        test_load_delayed();
        test_errors();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
